// File: rtl/source_e_arb.sv
// source_e_arb: round-robin arbiter for N GrantAck (E) requesters feeding a DEPTH-entry FIFO
// that drives a back-pressured TileLink E channel.
//
// Ports:
//   clock_i      clock, rising edge
//   reset_i      asynchronous active-high reset
//   req_valid_i  per-channel request valid                    [N]
//   req_ready_o  per-channel accept, at most one bit high     [N]
//   req_sink_i   channel i sink in bits [i*SINK_W +: SINK_W]  [N*SINK_W]
//   e_valid_o    E beat valid
//   e_ready_i    E beat accepted downstream
//   e_sink_o     E beat sink ID                               [SINK_W]
//   count_o      FIFO occupancy                               [clog2(DEPTH+1)]
module source_e_arb #(
    parameter int unsigned N      = 2,
    parameter int unsigned SINK_W = 3,
    parameter int unsigned DEPTH  = 2,
    parameter bit          PIPE   = 1'b0,
    parameter bit          FLOW   = 1'b0,
    localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic [N-1:0]        req_valid_i,
    output logic [N-1:0]        req_ready_o,
    input  logic [N*SINK_W-1:0] req_sink_i,
    output logic                e_valid_o,
    input  logic                e_ready_i,
    output logic [SINK_W-1:0]   e_sink_o,
    output logic [CntW-1:0]     count_o
);

    localparam int unsigned     PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     LastW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [PtrW-1:0] PtrMax   = PtrW'(DEPTH - 1);
    localparam logic [LastW-1:0] LastInit = LastW'(N - 1);
    localparam logic [CntW-1:0] CntFull  = CntW'(DEPTH);

    logic [SINK_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [LastW-1:0]  last_q, last_d;

    logic [N-1:0]      hi_mask;
    logic [N-1:0]      pick_src;
    logic [N-1:0]      grant;
    logic [LastW-1:0]  grant_idx;
    logic [SINK_W-1:0] grant_sink;
    logic              empty, can_enq, accept, bypass, enq_write, deq_read;

    // Channels above the last winner take priority; if none of them is valid the search
    // wraps to the lowest valid channel.
    always_comb begin
        hi_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            hi_mask[i] = (LastW'(i) > last_q);
        end
        pick_src   = ((req_valid_i & hi_mask) != '0) ? (req_valid_i & hi_mask) : req_valid_i;
        grant      = pick_src & (~pick_src + 1'b1);
        grant_idx  = last_q;
        grant_sink = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx  = LastW'(i);
                grant_sink = req_sink_i[i*SINK_W +: SINK_W];
            end
        end
    end

    assign empty       = (count_q == '0);
    assign can_enq     = (count_q < CntFull) | (PIPE & e_ready_i & (count_q == CntFull));
    assign req_ready_o = grant & {N{can_enq}};
    assign accept      = |(req_valid_i & req_ready_o);
    // Bypassed beat goes straight out and never touches the FIFO.
    assign bypass      = FLOW & accept & empty & e_ready_i;
    assign enq_write   = accept & ~bypass;
    assign deq_read    = ~empty & e_ready_i;

    assign e_valid_o   = ~empty | (FLOW & accept & empty);
    assign e_sink_o    = empty ? grant_sink : mem_q[rd_ptr_q];
    assign count_o     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        count_d  = count_q;
        if (accept) begin
            last_d = grant_idx;
        end
        if (enq_write) begin
            wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
        end
        if (deq_read) begin
            rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({enq_write, deq_read})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= LastInit;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q says they are valid.
    always_ff @(posedge clock_i) begin
        if (enq_write) begin
            mem_q[wr_ptr_q] <= grant_sink;
        end
    end

endmodule

// File: doc/source_e_arb.md
Name: source_e_arb

Overview:
- Parametrised successor of the single-requester E-channel source: accepts GrantAck (E) requests from N independent requesters and arbitrates them round-robin.
- Buffers accepted requests in a DEPTH-entry FIFO and drives a TileLink E channel that, unlike the previous generation, honours back-pressure (e_ready).
- Sits between the cache's grant-handling units (one per MSHR group) and the outer TileLink port.

Parameters:
- N, 2, number of request channels (N >= 1).
- SINK_W, 3, width of the sink ID field.
- DEPTH, 2, FIFO entries (DEPTH >= 1).
- PIPE, 0, 1 = a full FIFO may accept an entry in the same cycle one dequeues.
- FLOW, 0, 1 = when the FIFO is empty, an accepted request is presented on E in the same cycle.

Ports:
- clock  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- req_valid  in  N  per-channel request valid.
- req_ready  out  N  per-channel accept; at most one bit high per cycle.
- req_sink  in  N*SINK_W  channel i sink in bits [i*SINK_W +: SINK_W].
- e_valid  out  1  E beat valid.
- e_ready  in  1  E beat accepted by the downstream port.
- e_sink  out  SINK_W  E beat sink ID.
- count  out  clog2(DEPTH+1)  number of FIFO entries currently occupied.

Behaviour:
- Reset (asynchronous): FIFO is emptied, count=0, e_valid=0, read and write pointers=0, and the round-robin pointer last=N-1, so channel 0 has first priority. req_ready follows its combinational equation. e_sink is don't-care while e_valid=0.
- Arbitration:
  - grant is one-hot: the first i with req_valid[i]=1, searching last+1, last+2, ... modulo N.
  - If no channel is valid, there is no grant.
  - grant is combinational; it must not depend on req_ready.
- Space:
  - can_enq = (count<DEPTH) | (PIPE & e_ready & count==DEPTH).
  - With FLOW=1 and count==0, can_enq additionally requires e_ready=1 or a free slot. A free slot always exists at count==0, so can_enq=1.
- Accept: req_ready[i] = grant[i] & can_enq. A request is accepted when req_valid[i] & req_ready[i].
- Round-robin pointer:
  - On an accept, last <= i on the next edge.
  - Without an accept, last holds; a grant that is not accepted (FIFO full) does not advance it.
- Output:
  - e_valid = (count!=0) | (FLOW & accept & count==0).
  - e_sink = FIFO head, or the accepted req_sink on the FLOW bypass path.
  - deq = e_valid & e_ready.
- FLOW bypass: an accept with count==0 and e_ready=1 does not write the FIFO; count stays 0. With e_ready=0 the entry is written normally.
- FIFO and count update:
  - count_next = count + enq_write - deq_read, where a bypassed beat counts as neither a write nor a read.
  - Pointers wrap from DEPTH-1 to 0. Non-power-of-2 DEPTH must wrap correctly.
  - count never exceeds DEPTH or goes below 0.
- Latency: with FLOW=0, an accepted request appears on E the next cycle at the earliest.
- Order: E beats leave in accept order. Entries are never dropped or duplicated.
- Stability: while e_valid=1 and e_ready=0, e_sink is held unchanged. Exception: the FLOW bypass path, which is valid only in the cycle of accept.
- Simultaneous enqueue and dequeue at 0<count<DEPTH: count is unchanged.
- Reset mid-operation: all buffered entries are discarded immediately (asynchronously). Output is e_valid=0 from the assertion of reset.

Test Plan:
- Reset with N=3, SINK_W=3, DEPTH=2 defaults -> e_valid=0, count=0. Assert all req_valid=3'b111 -> req_ready=3'b001, so channel 0 wins first.
- All three channels valid continuously with sinks 1,2,3 and e_ready=1 -> E sinks appear 1,2,3,1,2,3 in successive cycles (one per cycle after the first). count stays <=1.
- e_ready=0, channel 1 valid with sink 5 then sink 6 -> count goes 1 then 2, and req_ready=0 on the third attempt. Then e_ready=1 -> E emits 5, then 6, and count returns to 0.
- PIPE=1, FIFO full (count=2), e_ready=1 and req_valid[2] with sink 7 -> accept in the same cycle, count stays 2, and sink 7 emerges third.
- FLOW=1, empty FIFO, e_ready=1, channel 0 sink 4 -> e_valid=1 with e_sink=4 in the same cycle, and count stays 0. Repeat with e_ready=0 -> the entry is buffered, count=1, and 4 is emitted on a later cycle.
- DEPTH=3, e_ready toggling randomly for 1000 cycles with random req_valid -> the E output sequence equals the accept-order scoreboard, count equals the number of outstanding entries, and the pointers wrap with no loss. Assert reset mid-stream -> e_valid drops immediately and count=0.
